// File: rtl/axil_regbank.sv
// AXI4-Lite slave register bank, DEPTH x DATA_W, byte strobes, SLVERR on out-of-range index.
// Latency: bvalid 2 cycles after the later AW/W handshake; rvalid 1 cycle after AR handshake.
// Backpressure: one write and one read in flight; awready/wready/arready drop until bready/rready.
// Optional AXIL_REGBANK_WR_PULSE_EN adds wr_pulse, a one-hot strobe aligned with the regs_flat update.
module axil_regbank #(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 8,
    parameter int                ADDR_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                     aclk,
    input  logic                     resetn,
    output logic [DEPTH*DATA_W-1:0]  regs_flat,
    input  logic [ADDR_W-1:0]        awaddr,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    input  logic [ADDR_W-1:0]        araddr,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [DATA_W-1:0]        rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
`ifdef AXIL_REGBANK_WR_PULSE_EN
    output logic [DEPTH-1:0]         wr_pulse,
`endif
    input  logic                     rready
);

    localparam int BSH    = (DATA_W == 64) ? 3 : 2;
    localparam int AIDX_W = ADDR_W - BSH;
    localparam int AIDX_X = AIDX_W + 1;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int STRB_W = DATA_W / 8;
    // One extra bit so DEPTH == 2**AIDX_W does not wrap to zero.
    localparam logic [AIDX_W:0] DEPTH_A = AIDX_X'(DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    generate
        if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
            $error("axil_regbank: DATA_W must be 32 or 64");
        end
        if (DEPTH < 2) begin : g_bad_depth
            $error("axil_regbank: DEPTH must be at least 2");
        end
        if (AIDX_W < 31 && (1 << AIDX_W) < DEPTH) begin : g_bad_addr_w
            $error("axil_regbank: ADDR_W too narrow for DEPTH");
        end
    endgenerate

    typedef enum logic [2:0] {W_IDLE, W_WAIT_D, W_WAIT_A, W_COMMIT, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    wstate_t             wstate;
    rstate_t             rstate;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic [AIDX_W-1:0]   w_idx;
    logic [DATA_W-1:0]   w_data;
    logic [STRB_W-1:0]   w_strb;
    logic [AIDX_W-1:0]   aw_idx;
    logic [AIDX_W-1:0]   ar_idx;
    logic                w_inr;
    logic                ar_inr;
    logic                unused_addr_lsbs;

    // Word index decode; byte-offset bits are intentionally ignored.
    assign aw_idx           = awaddr[ADDR_W-1:BSH];
    assign ar_idx           = araddr[ADDR_W-1:BSH];
    assign w_inr            = ({1'b0, w_idx}  < DEPTH_A);
    assign ar_inr           = ({1'b0, ar_idx} < DEPTH_A);
    assign unused_addr_lsbs = ^{awaddr[BSH-1:0], araddr[BSH-1:0]};

    // Flat export of every register, combinational.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign regs_flat[gi*DATA_W +: DATA_W] = regs[gi];
        end
    endgenerate

    // Write FSM: collects AW and W in either order, commits once, then holds the response.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            wstate  <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b1;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            w_idx   <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (awvalid) begin
                        w_idx <= aw_idx;
                    end
                    if (wvalid) begin
                        w_data <= wdata;
                        w_strb <= wstrb;
                    end
                    if (awvalid && wvalid) begin
                        awready <= 1'b0;
                        wready  <= 1'b0;
                        wstate  <= W_COMMIT;
                    end else if (awvalid) begin
                        awready <= 1'b0;
                        wstate  <= W_WAIT_D;
                    end else if (wvalid) begin
                        wready  <= 1'b0;
                        wstate  <= W_WAIT_A;
                    end
                end
                W_WAIT_D: begin
                    if (wvalid) begin
                        w_data <= wdata;
                        w_strb <= wstrb;
                        wready <= 1'b0;
                        wstate <= W_COMMIT;
                    end
                end
                W_WAIT_A: begin
                    if (awvalid) begin
                        w_idx   <= aw_idx;
                        awready <= 1'b0;
                        wstate  <= W_COMMIT;
                    end
                end
                W_COMMIT: begin
                    if (w_inr) begin
                        for (int k = 0; k < STRB_W; k++) begin
                            if (w_strb[k]) begin
                                regs[w_idx[IDX_W-1:0]][k*8 +: 8] <= w_data[k*8 +: 8];
                            end
                        end
                        bresp <= RESP_OKAY;
                    end else begin
                        bresp <= RESP_SLVERR;
                    end
                    bvalid <= 1'b1;
                    wstate <= W_RESP;
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wready  <= 1'b1;
                        wstate  <= W_IDLE;
                    end
                end
                default: begin
                    wstate  <= W_IDLE;
                    awready <= 1'b1;
                    wready  <= 1'b1;
                    bvalid  <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: samples the register on the AR handshake and holds it until rready.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            rstate  <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rresp   <= RESP_OKAY;
            rdata   <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (arvalid) begin
                        rdata   <= ar_inr ? regs[ar_idx[IDX_W-1:0]] : '0;
                        rresp   <= ar_inr ? RESP_OKAY : RESP_SLVERR;
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rstate  <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        rstate  <= R_IDLE;
                    end
                end
                default: begin
                    rstate  <= R_IDLE;
                    arready <= 1'b1;
                    rvalid  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXIL_REGBANK_WR_PULSE_EN
    // One-hot commit strobe, aligned with the regs_flat update, fires even for wstrb = 0.
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (wstate == W_COMMIT && w_inr) begin
                wr_pulse[w_idx[IDX_W-1:0]] <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axil_regbank.sv
// Directed bench for axil_regbank at DATA_W=32, DEPTH=8, ADDR_W=8, RESET_VAL=0.
// Inputs change and outputs are sampled 1ns after each rising edge.
// A small register model supplies the expected regs_flat image.
module tb_axil_regbank;

    localparam int DW = 32;
    localparam int DP = 8;
    localparam int AW = 8;

    logic            aclk = 1'b0;
    logic            resetn = 1'b0;
    logic [DP*DW-1:0] regs_flat;
    logic [AW-1:0]   awaddr = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;
    logic [AW-1:0]   araddr = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready = 1'b0;
`ifdef AXIL_REGBANK_WR_PULSE_EN
    logic [DP-1:0]   wr_pulse;
`endif

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model [DP];

    axil_regbank #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .RESET_VAL('0)) dut (
        .aclk(aclk), .resetn(resetn), .regs_flat(regs_flat),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
`ifdef AXIL_REGBANK_WR_PULSE_EN
        .wr_pulse(wr_pulse),
`endif
        .rready(rready)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flat(input string tag);
        logic [DP*DW-1:0] exp;
        for (int i = 0; i < DP; i++) exp[i*DW +: DW] = model[i];
        checks++;
        assert (regs_flat === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, regs_flat, exp);
        end
    endtask

    // Drives AW after aw_dly cycles and W after w_dly cycles; lat counts cycles from the later handshake to bvalid.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, output logic [1:0] resp, output int lat);
        bit aw_done = 0;
        bit w_done  = 0;
        bit hs_aw, hs_w;
        int t = 0;
        int k;
        awaddr = addr; wdata = data; wstrb = strb;
        while (!(aw_done && w_done) && t < 50) begin
            awvalid = !aw_done && (t >= aw_dly);
            wvalid  = !w_done && (t >= w_dly);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            tick();
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done = 1;
            t++;
        end
        awvalid = 0; wvalid = 0;
        k = 1;
        while (!bvalid && k < 20) begin
            tick();
            k++;
        end
        lat  = (bvalid && aw_done && w_done) ? k : -1;
        resp = bresp;
        bready = 1;
        tick();
        bready = 0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp,
                            output logic ok);
        int n = 0;
        araddr = addr; arvalid = 1;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        tick();
        arvalid = 0;
        ok   = rvalid;
        data = rdata;
        resp = rresp;
        rready = 1;
        tick();
        rready = 0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs, bs;
        logic        ok;
        int          lat;

        for (int i = 0; i < DP; i++) model[i] = '0;

        // Reset held for 3 cycles
        resetn = 0;
        repeat (3) @(posedge aclk);
        #1;
        resetn = 1;
        check("rst_ready", {awready, wready, arready}, 3'b111);
        check("rst_valid", {bvalid, rvalid}, 2'b00);
        check("rst_resp", {bresp, rresp}, 4'b0000);
        check_flat("rst_flat");
        for (int i = 0; i < DP; i++) begin
            axi_read(8'(i * 4), rd, rs, ok);
            check("rst_rvalid", ok, 1'b1);
            check("rst_rdata", rd, 32'h0);
            check("rst_rresp", rs, 2'b00);
        end

        // Byte strobes 0101
        axi_write(8'h04, 32'hAABBCCDD, 4'b0101, 0, 0, bs, lat);
        model[1] = 32'h00BB00DD;
        check("strb_bresp", bs, 2'b00);
        check("strb_lat", lat, 2);
        axi_read(8'h04, rd, rs, ok);
        check("strb_rdata", rd, 32'h00BB00DD);

        // W first, AW 3 cycles later
        axi_write(8'h08, 32'h12345678, 4'hF, 3, 0, bs, lat);
        model[2] = 32'h12345678;
        check("wfirst_lat", lat, 2);
        check("wfirst_bresp", bs, 2'b00);
        check_flat("wfirst_flat");
        axi_write(8'h08, 32'h0, 4'hF, 0, 0, bs, lat);
        model[2] = 32'h0;
        check_flat("clear2_flat");
        // AW first, W 3 cycles later
        axi_write(8'h08, 32'h12345678, 4'hF, 0, 3, bs, lat);
        model[2] = 32'h12345678;
        check("awfirst_lat", lat, 2);
        check_flat("awfirst_flat");
        axi_write(8'h08, 32'h0, 4'hF, 0, 0, bs, lat);
        model[2] = 32'h0;
        // Both in the same cycle
        axi_write(8'h08, 32'h12345678, 4'hF, 0, 0, bs, lat);
        model[2] = 32'h12345678;
        check("same_lat", lat, 2);
        axi_read(8'h08, rd, rs, ok);
        check("same_rdata", rd, 32'h12345678);

        // Out of range index 8
        axi_write(8'h20, 32'hFFFFFFFF, 4'hF, 0, 0, bs, lat);
        check("oor_bresp", bs, 2'b10);
        check_flat("oor_flat");
        axi_read(8'h20, rd, rs, ok);
        check("oor_rresp", rs, 2'b10);
        check("oor_rdata", rd, 32'h0);

        // Backpressure on both responses
        awaddr = 8'h14; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        araddr = 8'h04; arvalid = 1;
        tick();
        awvalid = 0; wvalid = 0; arvalid = 0;
        tick();
        model[5] = 32'hCAFEF00D;
        for (int c = 0; c < 5; c++) begin
            check("bp_ctrl", {bvalid, bresp, rvalid, rresp, awready, wready, arready}, 10'b1_00_1_00_000);
            check("bp_rdata", rd === 32'h12345678 ? rdata : rdata, 32'h00BB00DD);
            tick();
        end
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        check("bp_release", {bvalid, rvalid, awready, wready, arready}, 5'b00111);
        check_flat("bp_flat");

        // Read captured on the W_COMMIT edge sees the old value
        awaddr = 8'h0C; wdata = 32'h55; wstrb = 4'hF;
        awvalid = 1; wvalid = 1;
        tick();
        awvalid = 0; wvalid = 0;
        araddr = 8'h0C; arvalid = 1;
        tick();
        arvalid = 0;
        model[3] = 32'h55;
        check("coll_valid", {bvalid, rvalid}, 2'b11);
        check("coll_old", rdata, 32'h0);
        check_flat("coll_flat");
        bready = 1; rready = 1;
        tick();
        bready = 0; rready = 0;
        axi_read(8'h0C, rd, rs, ok);
        check("coll_new", rd, 32'h55);

        // Reset while waiting for W; W arriving during reset must not write
        awaddr = 8'h18; awvalid = 1;
        tick();
        awvalid = 0;
        check("wait_d_ready", {awready, wready}, 2'b01);
        resetn = 0;
        wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
        tick();
        resetn = 1; wvalid = 0;
        for (int i = 0; i < DP; i++) model[i] = '0;
        repeat (3) tick();
        check("mrst_bvalid", bvalid, 1'b0);
        check("mrst_ready", {awready, wready, arready}, 3'b111);
        check_flat("mrst_flat");
        axi_read(8'h18, rd, rs, ok);
        check("mrst_rd6", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
